// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the FIFO controller slice.
package fifo_pkg;

    localparam int DEFAULT_AWIDTH = 4;

    // Occupancy must reach DEPTH itself, so it needs one extra bit over the address.
    function automatic int count_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer-facing bundle of the FIFO controller: requests, RAM strobes and status.
interface fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int AWIDTH = DEFAULT_AWIDTH
);
    localparam int CW = count_width(AWIDTH);

    logic              push;
    logic              pop;
    logic              flush;
    logic              clr_err;
    logic [CW-1:0]     af_level;
    logic [CW-1:0]     ae_level;
    logic              ram_wr_en;
    logic [AWIDTH-1:0] ram_wr_addr;
    logic              ram_rd_en;
    logic [AWIDTH-1:0] ram_rd_addr;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, flush, clr_err, af_level, ae_level,
        input  ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr, rd_valid,
        input  full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, clr_err, af_level, ae_level,
        output ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr, rd_valid,
        output full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping RAM pointer: advances by one per enabled cycle, rolls over modulo 2**AWIDTH.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int AWIDTH = DEFAULT_AWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [AWIDTH-1:0] value
);

    always_ff @(posedge clock) begin
        if (reset || clear)
            value <= '0;
        else if (inc)
            value <= value + 1'b1;
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: address generation, occupancy tracking, status and sticky error flags
// for an external RAM. The producer writes the RAM data directly.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AWIDTH = DEFAULT_AWIDTH
) (
    input logic        clock,
    input logic        reset,
    fifo_ctrl_if.slave bus
);

    localparam int            CW    = count_width(AWIDTH);
    localparam logic [CW-1:0] DEPTH = CW'(2 ** AWIDTH);

    logic [CW-1:0]     count_q;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic              rd_valid_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              is_full;
    logic              is_empty;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_set;
    logic              unf_set;

    assign is_full  = (count_q == DEPTH);
    assign is_empty = (count_q == '0);

    // Full/empty gating alone resolves simultaneous push+pop at the extremes.
    assign push_ok = bus.push & ~is_full  & ~bus.flush & ~reset;
    assign pop_ok  = bus.pop  & ~is_empty & ~bus.flush & ~reset;
    assign ovf_set = bus.push & is_full  & ~bus.flush;
    assign unf_set = bus.pop  & is_empty & ~bus.flush;

    fifo_ptr #(.AWIDTH(AWIDTH)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .clear (bus.flush),
        .inc   (push_ok),
        .value (wr_ptr)
    );

    fifo_ptr #(.AWIDTH(AWIDTH)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .clear (bus.flush),
        .inc   (pop_ok),
        .value (rd_ptr)
    );

    always_ff @(posedge clock) begin
        if (reset || bus.flush)
            count_q <= '0;
        else if (push_ok && !pop_ok)
            count_q <= count_q + 1'b1;
        else if (pop_ok && !push_ok)
            count_q <= count_q - 1'b1;
    end

    // A pop accepted just before a flush still delivers its data.
    always_ff @(posedge clock) begin
        if (reset)
            rd_valid_q <= 1'b0;
        else
            rd_valid_q <= pop_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set)
                overflow_q <= 1'b1;
            else if (bus.clr_err)
                overflow_q <= 1'b0;
            if (unf_set)
                underflow_q <= 1'b1;
            else if (bus.clr_err)
                underflow_q <= 1'b0;
        end
    end

    assign bus.ram_wr_en    = push_ok;
    assign bus.ram_wr_addr  = wr_ptr;
    assign bus.ram_rd_en    = pop_ok;
    assign bus.ram_rd_addr  = rd_ptr;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (count_q >= bus.af_level);
    assign bus.almost_empty = (count_q <= bus.ae_level);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: occupancy model checked every cycle plus directed literal checks.
module tb_fifo_ctrl;

    localparam int AWIDTH = 4;
    localparam int DEPTH  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    fifo_ctrl_if #(.AWIDTH(AWIDTH)) bus ();

    fifo_ctrl #(.AWIDTH(AWIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: occupancy and pointers as plain integers.
    int m_count = 0;
    int m_wr    = 0;
    int m_rd    = 0;
    bit m_rv    = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;
    bit m_valid = 0;
    bit acc_push;
    bit acc_pop;

    assign acc_push = bus.push && !bus.flush && !reset && (m_count < DEPTH);
    assign acc_pop  = bus.pop  && !bus.flush && !reset && (m_count > 0);

    always @(posedge clock) begin
        if (reset) begin
            m_count <= 0;
            m_wr    <= 0;
            m_rd    <= 0;
            m_rv    <= 0;
            m_ovf   <= 0;
            m_unf   <= 0;
            m_valid <= 1;
        end else if (bus.flush) begin
            m_count <= 0;
            m_wr    <= 0;
            m_rd    <= 0;
            m_rv    <= 0;
            if (bus.clr_err) begin
                m_ovf <= 0;
                m_unf <= 0;
            end
        end else begin
            m_count <= m_count + int'(acc_push) - int'(acc_pop);
            m_wr    <= (m_wr + int'(acc_push)) % DEPTH;
            m_rd    <= (m_rd + int'(acc_pop)) % DEPTH;
            m_rv    <= acc_pop;
            if (bus.push && !acc_push)
                m_ovf <= 1;
            else if (bus.clr_err)
                m_ovf <= 0;
            if (bus.pop && !acc_pop)
                m_unf <= 1;
            else if (bus.clr_err)
                m_unf <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            checkOutput("m.count",        32'(bus.count),        32'(m_count));
            checkOutput("m.full",         32'(bus.full),         32'(m_count == DEPTH));
            checkOutput("m.empty",        32'(bus.empty),        32'(m_count == 0));
            checkOutput("m.almost_full",  32'(bus.almost_full),  32'(m_count >= int'(bus.af_level)));
            checkOutput("m.almost_empty", 32'(bus.almost_empty), 32'(m_count <= int'(bus.ae_level)));
            checkOutput("m.ram_wr_en",    32'(bus.ram_wr_en),    32'(acc_push));
            checkOutput("m.ram_wr_addr",  32'(bus.ram_wr_addr),  32'(m_wr));
            checkOutput("m.ram_rd_en",    32'(bus.ram_rd_en),    32'(acc_pop));
            checkOutput("m.ram_rd_addr",  32'(bus.ram_rd_addr),  32'(m_rd));
            checkOutput("m.rd_valid",     32'(bus.rd_valid),     32'(m_rv));
            checkOutput("m.overflow",     32'(bus.overflow),     32'(m_ovf));
            checkOutput("m.underflow",    32'(bus.underflow),    32'(m_unf));
        end
    end

    task automatic applyStimulus(input bit p, input bit q, input bit f, input bit c);
        bus.push    = p;
        bus.pop     = q;
        bus.flush   = f;
        bus.clr_err = c;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0);
        bus.af_level = 5'd12;
        bus.ae_level = 5'd2;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst.empty", 32'(bus.empty), 1);
        checkOutput("rst.full",  32'(bus.full),  0);
        checkOutput("rst.count", 32'(bus.count), 0);
        checkOutput("rst.ae",    32'(bus.almost_empty), 1);
        checkOutput("rst.af",    32'(bus.almost_full),  0);

        // Fill 0 -> 16 with threshold crossings.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 0);
            #1;
            checkOutput("fill.wr_addr", 32'(bus.ram_wr_addr), 32'(i));
            checkOutput("fill.wr_en",   32'(bus.ram_wr_en),   1);
            if (i == 11) checkOutput("fill.af11", 32'(bus.almost_full), 0);
            if (i == 12) checkOutput("fill.af12", 32'(bus.almost_full), 1);
            if (i == 2)  checkOutput("fill.ae2",  32'(bus.almost_empty), 1);
            if (i == 3)  checkOutput("fill.ae3",  32'(bus.almost_empty), 0);
            step();
        end
        #1;
        checkOutput("full.count", 32'(bus.count), 16);
        checkOutput("full.full",  32'(bus.full),  1);
        checkOutput("push17.wr_en", 32'(bus.ram_wr_en), 0);
        step();
        checkOutput("push17.overflow", 32'(bus.overflow), 1);

        applyStimulus(1, 0, 0, 1);
        step();
        checkOutput("clr_vs_set.overflow", 32'(bus.overflow), 1);
        applyStimulus(0, 0, 0, 1);
        step();
        checkOutput("clr.overflow", 32'(bus.overflow), 0);

        // Drain 16 -> 0.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 0, 0);
            #1;
            checkOutput("drain.rd_addr", 32'(bus.ram_rd_addr), 32'(i));
            checkOutput("drain.rd_en",   32'(bus.ram_rd_en),   1);
            step();
            checkOutput("drain.rd_valid", 32'(bus.rd_valid), 1);
        end
        #1;
        checkOutput("empty.empty", 32'(bus.empty), 1);
        checkOutput("pop17.rd_en", 32'(bus.ram_rd_en), 0);
        step();
        checkOutput("pop17.underflow", 32'(bus.underflow), 1);
        checkOutput("pop17.rd_valid",  32'(bus.rd_valid), 0);
        applyStimulus(0, 0, 0, 1);
        step();
        checkOutput("clr.underflow", 32'(bus.underflow), 0);

        // Push+pop on empty: push wins, underflow set.
        applyStimulus(1, 1, 0, 0);
        #1;
        checkOutput("pp_empty.wr_en", 32'(bus.ram_wr_en), 1);
        checkOutput("pp_empty.rd_en", 32'(bus.ram_rd_en), 0);
        step();
        checkOutput("pp_empty.count",     32'(bus.count), 1);
        checkOutput("pp_empty.underflow", 32'(bus.underflow), 1);
        applyStimulus(1, 0, 0, 0);
        repeat (2) step();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("pairs.count",    32'(bus.count), 3);
        checkOutput("pairs.wr_addr",  32'(bus.ram_wr_addr), 7);
        checkOutput("pairs.rd_addr",  32'(bus.ram_rd_addr), 4);
        checkOutput("pairs.overflow", 32'(bus.overflow), 0);

        // Flush at count 7 with push+pop.
        applyStimulus(1, 0, 0, 0);
        repeat (4) step();
        checkOutput("preflush.count", 32'(bus.count), 7);
        applyStimulus(1, 1, 1, 0);
        #1;
        checkOutput("flush.wr_en", 32'(bus.ram_wr_en), 0);
        checkOutput("flush.rd_en", 32'(bus.ram_rd_en), 0);
        step();
        checkOutput("flush.count",     32'(bus.count), 0);
        checkOutput("flush.underflow", 32'(bus.underflow), 1);
        checkOutput("flush.overflow",  32'(bus.overflow), 0);

        // A pop just before flush still yields rd_valid.
        applyStimulus(1, 0, 0, 0);
        repeat (2) step();
        applyStimulus(0, 1, 0, 0);
        step();
        applyStimulus(0, 0, 1, 0);
        #1;
        checkOutput("flush.rd_valid_kept", 32'(bus.rd_valid), 1);
        step();
        checkOutput("flush2.count",    32'(bus.count), 0);
        checkOutput("flush2.rd_valid", 32'(bus.rd_valid), 0);

        // Reset mid-operation discards content.
        applyStimulus(1, 0, 0, 0);
        repeat (3) step();
        reset = 1'b1;
        #1;
        checkOutput("midrst.wr_en", 32'(bus.ram_wr_en), 0);
        step();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("midrst.count",     32'(bus.count), 0);
        checkOutput("midrst.empty",     32'(bus.empty), 1);
        checkOutput("midrst.underflow", 32'(bus.underflow), 0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
